// File: rtl/data_memory_port_if.sv
// CPU-side request/response bus of the data memory port.
interface data_memory_port_if #(
    parameter int unsigned MEMORY_BITS = 8
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [MEMORY_BITS-1:0] req_addr;
    logic [MEMORY_BITS-1:0] req_wdata;
    logic                   resp_valid;
    logic                   resp_ready;
    logic                   resp_write;
    logic [MEMORY_BITS-1:0] resp_rdata;

    // CPU execute stage side
    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_write, resp_rdata
    );

    // Access controller side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_write, resp_rdata
    );
endinterface

// File: rtl/data_memory_port.sv
// Load/store sequencer between the CPU and a single-port data memory that writes on
// posedge and latches read data on negedge while write enable is low.
module data_memory_port #(
    parameter int unsigned MEMORY_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    data_memory_port_if.slave      bus,
    output logic                   mem_write_enable,
    output logic [MEMORY_BITS-1:0] mem_address,
    output logic [MEMORY_BITS-1:0] mem_data_in,
    input  logic [MEMORY_BITS-1:0] mem_data_out
);
    typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

    state_e                 state_q, state_d;
    logic                   mem_we_q, mem_we_d;
    logic [MEMORY_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [MEMORY_BITS-1:0] mem_din_q, mem_din_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_write_q, resp_write_d;
    logic [MEMORY_BITS-1:0] resp_rdata_q, resp_rdata_d;
    logic                   req_ready;
    logic                   accept;

    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = bus.req_valid && req_ready;

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            resp_valid_q <= resp_valid_d;
            resp_write_q <= resp_write_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Next-state: accept -> one memory cycle -> hold response until consumed
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = bus.req_write ? StWrite : StRead;
            StWrite: state_d = StResp;
            StRead:  state_d = StResp;
            StResp:  if (resp_valid_q && bus.resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output next values; everything holds unless the current state updates it
    always_comb begin
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        resp_valid_d = resp_valid_q;
        resp_write_d = resp_write_q;
        resp_rdata_d = resp_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mem_addr_d = bus.req_addr;
                    if (bus.req_write) begin
                        mem_din_d = bus.req_wdata;
                        mem_we_d  = 1'b1;
                    end else begin
                        mem_we_d  = 1'b0;
                    end
                end
            end
            StWrite: begin
                // Memory commits at this edge; drop enable so it writes exactly once
                mem_we_d     = 1'b0;
                resp_valid_d = 1'b1;
                resp_write_d = 1'b1;
                resp_rdata_d = '0;
            end
            StRead: begin
                // mem_data_out was latched by the memory at the mid-cycle negedge
                resp_rdata_d = mem_data_out;
                resp_valid_d = 1'b1;
                resp_write_d = 1'b0;
            end
            StResp: begin
                if (resp_valid_q && bus.resp_ready) resp_valid_d = 1'b0;
            end
            default: begin
                mem_we_d = 1'b0;
            end
        endcase
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_write = resp_write_q;
    assign bus.resp_rdata = resp_rdata_q;

    assign mem_write_enable = mem_we_q;
    assign mem_address      = mem_addr_q;
    assign mem_data_in      = mem_din_q;
endmodule
